// File: rtl/led_cnt_pkg.sv
// Shared types for the multi-channel LED divider: channel modes, default
// field widths and the {mode, div, duty} config record.
package led_cnt_pkg;

  localparam int DEF_DIV_W  = 5;
  localparam int DEF_DUTY_W = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    led_mode_e               mode;
    logic [DEF_DIV_W-1:0]    div;
    logic [DEF_DUTY_W-1:0]   duty;
  } led_cfg_t;

  // Channel select is never narrower than one bit, even for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_cnt_ch.sv
// One LED channel: write-matched config register plus a registered LED bit
// derived from the shared prescaler. LED_CNT_MULTI_RDBACK_EN exposes the config.
module led_cnt_ch
  import led_cnt_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter int         DIV_W    = DEF_DIV_W,
  parameter int         DUTY_W   = DEF_DUTY_W,
  parameter int         SEL_W    = 2,
  parameter int         CH_IDX   = 0,
  parameter logic [1:0] RST_MODE = 2'd2,
  parameter int         RST_DIV  = 24
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              wren_i,
  input  logic [SEL_W-1:0]  ch_sel_i,
  input  logic [1:0]        mode_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [CNT_W-1:0]  cnt_i,
`ifdef LED_CNT_MULTI_RDBACK_EN
  output logic [2+DIV_W+DUTY_W-1:0] cfg_o,
`endif
  output logic              led_o
);

  localparam int TAP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  led_mode_e         mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [DUTY_W-1:0] duty_q;
  logic              wr_hit;
  logic [TAP_W-1:0]  tap;
  logic              led_d;

  assign wr_hit = wren_i && (ch_sel_i == SEL_W'(CH_IDX));

  always_ff @(posedge clk100) begin
    if (rst) begin
      mode_q <= led_mode_e'(RST_MODE);
      div_q  <= DIV_W'(RST_DIV);
      duty_q <= '0;
    end else if (wr_hit) begin
      mode_q <= led_mode_e'(mode_i);
      div_q  <= div_i;
      duty_q <= duty_i;
    end
  end

  // Divider values past the top counter bit fall back to the slowest tap.
  always_comb begin
    tap = TAP_W'(div_q);
    if (int'(div_q) >= CNT_W) tap = TAP_W'(CNT_W - 1);
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_OFF:   led_d = 1'b0;
      MODE_ON:    led_d = 1'b1;
      MODE_BLINK: led_d = cnt_i[tap];
      MODE_PWM:   led_d = (cnt_i[DUTY_W-1:0] < duty_q);
      default:    led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) led_o <= 1'b0;
    else     led_o <= led_d;
  end

`ifdef LED_CNT_MULTI_RDBACK_EN
  assign cfg_o = {mode_q, div_q, duty_q};
`endif

endmodule

// File: rtl/led_cnt_multi.sv
// Multi-channel LED driver: shared free-running prescaler feeding NUM_CH
// configurable channels. LED_CNT_MULTI_RDBACK_EN adds a registered config readback.
module led_cnt_multi
  import led_cnt_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         CNT_W    = 32,
  parameter int         DIV_W    = DEF_DIV_W,
  parameter int         DUTY_W   = DEF_DUTY_W,
  parameter logic [1:0] RST_MODE = 2'd2,
  parameter int         RST_DIV  = 24,
  localparam int        SEL_W    = sel_width(NUM_CH),
  localparam int        CFG_W    = 2 + DIV_W + DUTY_W
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              wren_i,
  input  logic [SEL_W-1:0]  ch_sel_i,
  input  logic [1:0]        mode_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DUTY_W-1:0] duty_i,
`ifdef LED_CNT_MULTI_RDBACK_EN
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CFG_W-1:0]  rd_cfg_o,
`endif
  output logic [NUM_CH-1:0] led_o
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk100) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + CNT_W'(1);
  end

`ifdef LED_CNT_MULTI_RDBACK_EN
  logic [CFG_W-1:0] ch_cfg [NUM_CH];
`endif

  // Each channel matches its own index, so selects >= NUM_CH hit nothing.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    led_cnt_ch #(
      .CNT_W    (CNT_W),
      .DIV_W    (DIV_W),
      .DUTY_W   (DUTY_W),
      .SEL_W    (SEL_W),
      .CH_IDX   (gi),
      .RST_MODE (RST_MODE),
      .RST_DIV  (RST_DIV)
    ) u_ch (
      .clk100   (clk100),
      .rst      (rst),
      .wren_i   (wren_i),
      .ch_sel_i (ch_sel_i),
      .mode_i   (mode_i),
      .div_i    (div_i),
      .duty_i   (duty_i),
      .cnt_i    (cnt),
`ifdef LED_CNT_MULTI_RDBACK_EN
      .cfg_o    (ch_cfg[gi]),
`endif
      .led_o    (led_o[gi])
    );
  end

`ifdef LED_CNT_MULTI_RDBACK_EN
  // Reads sample the config before any same-edge write lands.
  always_ff @(posedge clk100) begin
    if (rst)                          rd_cfg_o <= '0;
    else if (int'(rd_sel_i) < NUM_CH) rd_cfg_o <= ch_cfg[rd_sel_i];
    else                              rd_cfg_o <= '0;
  end
`endif

endmodule

// File: tb/tb_led_cnt_multi.sv
// Directed bench for led_cnt_multi: a 4-channel and a 3-channel instance share
// one stimulus bus; a cycle model tracks both alongside hand-computed checks.
module tb_led_cnt_multi;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic       wren_i = 1'b0;
  logic [1:0] ch_sel_i = '0;
  logic [1:0] mode_i   = '0;
  logic [4:0] div_i    = '0;
  logic [7:0] duty_i   = '0;
  logic [3:0] led_o;
  logic [2:0] led3_o;
`ifdef LED_CNT_MULTI_RDBACK_EN
  logic [1:0]  rd_sel_i = '0;
  logic [14:0] rd_cfg_o;
  logic [14:0] rd3_cfg_o;
  logic [14:0] m_rd, m_rd3;
`endif

  always #5 clk100 = ~clk100;

  led_cnt_multi #(
    .NUM_CH(4), .CNT_W(8), .DIV_W(5), .DUTY_W(8), .RST_MODE(2'd2), .RST_DIV(2)
  ) u_dut (
    .clk100   (clk100),
    .rst      (rst),
    .wren_i   (wren_i),
    .ch_sel_i (ch_sel_i),
    .mode_i   (mode_i),
    .div_i    (div_i),
    .duty_i   (duty_i),
`ifdef LED_CNT_MULTI_RDBACK_EN
    .rd_sel_i (rd_sel_i),
    .rd_cfg_o (rd_cfg_o),
`endif
    .led_o    (led_o)
  );

  led_cnt_multi #(
    .NUM_CH(3), .CNT_W(8), .DIV_W(5), .DUTY_W(8), .RST_MODE(2'd2), .RST_DIV(2)
  ) u_dut3 (
    .clk100   (clk100),
    .rst      (rst),
    .wren_i   (wren_i),
    .ch_sel_i (ch_sel_i),
    .mode_i   (mode_i),
    .div_i    (div_i),
    .duty_i   (duty_i),
`ifdef LED_CNT_MULTI_RDBACK_EN
    .rd_sel_i (rd_sel_i),
    .rd_cfg_o (rd3_cfg_o),
`endif
    .led_o    (led3_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int trace_err = 0;

  logic [7:0] m_cnt;
  logic [3:0] m_led;
  logic [1:0] m_mode [4];
  logic [4:0] m_div  [4];
  logic [7:0] m_duty [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge,
  // then compare both instances against it 1 time unit later.
  task automatic tick();
    int t;
    @(posedge clk100);
    if (rst) begin
      m_cnt = '0;
      m_led = '0;
`ifdef LED_CNT_MULTI_RDBACK_EN
      m_rd  = '0;
      m_rd3 = '0;
`endif
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 2'd2;
        m_div[i]  = 5'd2;
        m_duty[i] = 8'd0;
      end
    end else begin
`ifdef LED_CNT_MULTI_RDBACK_EN
      m_rd  = {m_mode[rd_sel_i], m_div[rd_sel_i], m_duty[rd_sel_i]};
      m_rd3 = (rd_sel_i < 2'd3) ? {m_mode[rd_sel_i], m_div[rd_sel_i], m_duty[rd_sel_i]} : '0;
`endif
      for (int i = 0; i < 4; i++) begin
        t = (m_div[i] >= 5'd8) ? 7 : int'(m_div[i]);
        case (m_mode[i])
          2'd0: m_led[i] = 1'b0;
          2'd1: m_led[i] = 1'b1;
          2'd2: m_led[i] = m_cnt[t];
          default: m_led[i] = (m_cnt < m_duty[i]);
        endcase
      end
      if (wren_i) begin
        m_mode[ch_sel_i] = mode_i;
        m_div[ch_sel_i]  = div_i;
        m_duty[ch_sel_i] = duty_i;
      end
      m_cnt = m_cnt + 8'd1;
    end
    #1;
    if (led_o !== m_led || led3_o !== m_led[2:0]) trace_err++;
`ifdef LED_CNT_MULTI_RDBACK_EN
    if (rd_cfg_o !== m_rd || rd3_cfg_o !== m_rd3) trace_err++;
`endif
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [1:0] md,
                          input logic [4:0] dv, input logic [7:0] dt);
    ch_sel_i = sel;
    mode_i   = md;
    div_i    = dv;
    duty_i   = dt;
    wren_i   = 1'b1;
    tick();
    wren_i   = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int highs, output int max_run);
    int run;
    highs = 0;
    run = 0;
    max_run = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (led_o[ch]) begin
        highs++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  endtask

  initial begin
    int highs, run;

    tick();
    tick();
    chk("rst_led", led_o, 4'h0);
    chk("rst_led3", led3_o, 3'h0);
`ifdef LED_CNT_MULTI_RDBACK_EN
    chk("rst_rd", rd_cfg_o, 15'h0);
`endif

    // Tap 2: LEDs follow cnt[2] one edge late, all channels in phase.
    rst = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      tick();
      chk($sformatf("blink_m%0d", m), led_o, (((m - 1) & 4) != 0) ? 4'hF : 4'h0);
    end

    do_write(2'd1, 2'd1, 5'd2, 8'd0);
    tick();
    chk("ch1_on", led_o[1], 1'b1);
    do_write(2'd1, 2'd0, 5'd2, 8'd0);
    tick();
    chk("ch1_off", led_o[1], 1'b0);
    chk("trace_a", trace_err, 0);

    do_write(2'd2, 2'd3, 5'd0, 8'd64);
    count_high(2, 256, highs, run);
    chk("pwm64_highs", highs, 64);
    do_write(2'd2, 2'd3, 5'd0, 8'd0);
    count_high(2, 256, highs, run);
    chk("pwm0_highs", highs, 0);
    do_write(2'd2, 2'd3, 5'd0, 8'd255);
    count_high(2, 256, highs, run);
    chk("pwm255_highs", highs, 255);

    do_write(2'd0, 2'd2, 5'd31, 8'd0);
    count_high(0, 512, highs, run);
    chk("clamp_highs", highs, 256);
    chk("clamp_run", run, 128);

    // Select 3 is a real channel on the 4-channel part, out of range on the 3-channel one.
    do_write(2'd3, 2'd1, 5'd2, 8'd0);
    tick();
    chk("ch3_on", led_o[3], 1'b1);
    chk("trace_b", trace_err, 0);

    rst = 1'b1;
    do_write(2'd0, 2'd1, 5'd0, 8'd0);
    rst = 1'b0;
    chk("rst2_led", led_o, 4'h0);
    for (int m = 1; m <= 5; m++) begin
      tick();
      chk($sformatf("rst2_m%0d", m), led_o, (m == 5) ? 4'hF : 4'h0);
    end
    chk("rst2_led3", led3_o, 3'h7);

`ifdef LED_CNT_MULTI_RDBACK_EN
    rd_sel_i = 2'd3;
    do_write(2'd3, 2'd2, 5'd5, 8'd9);
    chk("rd_old", rd_cfg_o, {2'd2, 5'd2, 8'd0});
    tick();
    chk("rd_new", rd_cfg_o, {2'd2, 5'd5, 8'd9});
    chk("rd_oor", rd3_cfg_o, 15'h0);
    rd_sel_i = 2'd1;
    tick();
    chk("rd_ch1", rd_cfg_o, {2'd2, 5'd2, 8'd0});
    chk("rd3_ch1", rd3_cfg_o, {2'd2, 5'd2, 8'd0});
`endif

    chk("trace_end", trace_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
